// File: rtl/nibble_arith_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width, index sizing.
package nibble_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Bits needed to count n values; never fewer than one so a single-nibble index still exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder built from full adders.
module nibble_add4
  import nibble_arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder sequenced over one shared nibble adder, LSB nibble first, one nibble per clock.
// Optional macro SUBTRACT_EN adds in_sub to compute A-B instead of A+B+cin.
module nibble_serial_add_ctrl
  import nibble_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // A source holds valid and data until that edge; ready never depends on valid.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SUBTRACT_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = clog2(NIBBLES);

  typedef logic [IDX_W-1:0] idx_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;
  idx_t                 idx_q;

  logic [WIDTH-1:0]     b_load;
  logic                 c_load;
  logic                 last_nib;
  logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_sum;
  logic                 nib_cout, msb_cin;

  // Subtraction is A + ~B + 1, so inversion happens once at capture time.
`ifdef SUBTRACT_EN
  assign b_load = in_sub ? ~in_b : in_b;
  assign c_load = in_sub | in_cin;
`else
  assign b_load = in_b;
  assign c_load = in_cin;
`endif

  assign last_nib = (idx_q == idx_t'(NIBBLES - 1));
  assign nib_a    = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b    = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_add4 u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Carry into the top bit of the top nibble, recovered from its sum bit.
  assign msb_cin = nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= b_load;
            carry_q <= c_load;
            sum_q   <= '0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_sum;
          carry_q                           <= nib_cout;
          if (last_nib) begin
            cout_q <= nib_cout;
            ovf_q  <= msb_cin ^ nib_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl at WIDTH=16 plus a WIDTH=4 instance.
module tb_nibble_serial_add_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic [1:0]    dbg;
  logic          v4, rdy4, cin4, ov4, ordy4, cout4, ovf4, busy4;
  logic [3:0]    a4, b4, sum4;
  logic [1:0]    dbg4;
`ifdef SUBTRACT_EN
  logic          in_sub, sub4;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [W+1:0] exp_q[$];  // {ovf, cout, sum}

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SUBTRACT_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy), .dbg_state(dbg)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(rdy4),
    .in_a(a4), .in_b(b4), .in_cin(cin4),
`ifdef SUBTRACT_EN
    .in_sub(sub4),
`endif
    .out_valid(ov4), .out_ready(ordy4),
    .out_sum(sum4), .out_cout(cout4), .out_ovf(ovf4),
    .busy(busy4), .dbg_state(dbg4)
  );

  // Reference: plain integer addition; subtraction as A + ~B + 1.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic         ce, ovf;
    logic [W:0]   full;
    be   = sub ? ~b : b;
    ce   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (out_sum !== '0)     begin miscompares++; $display("FAIL rst_sum: got %h want 0", out_sum); end
    vectors++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got %b%b want 00", out_cout, out_ovf); end
    vectors++; if (dbg !== 2'd0)       begin miscompares++; $display("FAIL rst_state: got %0d want 0", dbg); end
    vectors++; if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin miscompares++; $display("FAIL rst_w4: got rdy=%b ov=%b want 1 0", rdy4, ov4); end
  endtask

  // Driver + checker for one full operation; starts and ends just after a falling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int cyc, bcnt;
    logic [W+1:0] e;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL op_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
`ifdef SUBTRACT_EN
    in_sub = sub;
`endif
    exp_q.push_back(model(a, b, cin, sub));
    @(negedge clk);
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom_range(0, 1));
`ifdef SUBTRACT_EN
    in_sub = 1'($urandom_range(0, 1));
`endif
    cyc = 0; bcnt = 0;
    while (!out_valid && cyc < 50) begin
      if (busy) bcnt++;
      @(negedge clk); cyc++;
    end
    vectors++; if (cyc != N)  begin miscompares++; $display("FAIL op_latency: got %0d want %0d", cyc, N); end
    vectors++; if (bcnt != N) begin miscompares++; $display("FAIL op_busy_cycles: got %0d want %0d", bcnt, N); end
    vectors++; if (dbg !== 2'd2) begin miscompares++; $display("FAIL op_state: got %0d want 2", dbg); end
    if (exp_q.size() == 0) begin
      vectors++; miscompares++; $display("FAIL op_scoreboard: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      vectors++; if (out_sum !== e[W-1:0]) begin miscompares++; $display("FAIL op_sum a=%h b=%h: got %h want %h", a, b, out_sum, e[W-1:0]); end
      vectors++; if (out_cout !== e[W])    begin miscompares++; $display("FAIL op_cout a=%h b=%h: got %b want %b", a, b, out_cout, e[W]); end
      vectors++; if (out_ovf !== e[W+1])   begin miscompares++; $display("FAIL op_ovf a=%h b=%h: got %b want %b", a, b, out_ovf, e[W+1]); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL op_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_add_vectors();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [W+1:0] e;
    in_valid = 1'b1; in_a = 16'hA5A5; in_b = 16'h0F0F; in_cin = 1'b0;
    e = model(16'hA5A5, 16'h0F0F, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
    repeat (10) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b want 1", out_valid); end
      vectors++; if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      vectors++; if (out_sum !== e[W-1:0] || out_cout !== e[W]) begin miscompares++; $display("FAIL bp_hold: got %h/%b want %h/%b", out_sum, out_cout, e[W-1:0], e[W]); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle: got %b want 1", in_ready); end
    vectors++; if (out_sum !== e[W-1:0]) begin miscompares++; $display("FAIL bp_no_capture: got %h want %h", out_sum, e[W-1:0]); end
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mr_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mr_ctrl: got rdy=%b val=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    vectors++; if (out_sum !== '0) begin miscompares++; $display("FAIL mr_sum: got %h want 0", out_sum); end
    vectors++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin miscompares++; $display("FAIL mr_flags: got %b%b want 00", out_cout, out_ovf); end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc, accepts, results, last_acc;
    logic acc;
    logic [W+1:0] e;
    cyc = 0; accepts = 0; results = 0; last_acc = -1;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1; out_ready = 1'b1;
    while (results < 3 && cyc < 100) begin
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(in_a, in_b, in_cin, 1'b0));
        if (last_acc >= 0) begin
          vectors++; if (cyc - last_acc != N + 2) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, N + 2); end
        end
        last_acc = cyc;
        accepts++;
      end
      if (out_valid) begin
        e = exp_q.pop_front();
        vectors++; if (out_sum !== e[W-1:0] || out_cout !== e[W]) begin miscompares++; $display("FAIL b2b_result: got %h/%b want %h/%b", out_sum, out_cout, e[W-1:0], e[W]); end
        results++;
      end
      @(negedge clk); cyc++;
      if (acc) begin
        if (accepts < 3) begin
          in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    vectors++; if (results != 3) begin miscompares++; $display("FAIL b2b_count: got %0d want 3", results); end
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int cyc;
    logic [4:0] full;
    logic ovf;
    full = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    ovf  = (a[3] == b[3]) && (full[3] != a[3]);
    v4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
    @(negedge clk);
    v4 = 1'b0; a4 = 4'($urandom);
    cyc = 0;
    while (!ov4 && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++; if (cyc != 1) begin miscompares++; $display("FAIL w4_latency: got %0d want 1", cyc); end
    vectors++; if (sum4 !== full[3:0] || cout4 !== full[4] || ovf4 !== ovf) begin miscompares++; $display("FAIL w4_result a=%h b=%h: got %h/%b/%b want %h/%b/%b", a, b, sum4, cout4, ovf4, full[3:0], full[4], ovf); end
    vectors++; if (dbg4 !== 2'd2) begin miscompares++; $display("FAIL w4_state: got %0d want 2", dbg4); end
    ordy4 = 1'b1;
    @(negedge clk);
    ordy4 = 1'b0;
  endtask

  task automatic test_width4();
    run_op4(4'hF, 4'h1, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract();
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op(16'h0009, 16'h0002, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; ordy4 = 1'b0;
`ifdef SUBTRACT_EN
    in_sub = 1'b0; sub4 = 1'b0;
`endif
    test_reset();
    test_add_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width4();
`ifdef SUBTRACT_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
